// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and memory-load result streams into the
// single register file write port. Each source has its own FIFO; memory has
// fixed priority, and a starvation counter forces an ALU grant after STARVE
// consecutive losses.
module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int LW     = 3,
    parameter int STARVE = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_vld,
    output logic          alu_rdy,
    input  logic [4:0]    alu_wta,
    input  logic [31:0]   alu_wtd,
    input  logic          mem_vld,
    output logic          mem_rdy,
    input  logic [4:0]    mem_wta,
    input  logic [31:0]   mem_wtd,
    output logic [31:0]   wtd,
    output logic [4:0]    wta,
    output logic          cnt,
    output logic [LW-1:0] alu_lvl,
    output logic [LW-1:0] mem_lvl,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE + 1);
    localparam int EW = 37;

    // FIFO storage holds {wta, wtd}; contents are don't-care until written
    logic [EW-1:0] alu_mem_q [DEPTH];
    logic [EW-1:0] mem_mem_q [DEPTH];

    logic [AW-1:0] alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
    logic [AW-1:0] mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
    logic [LW-1:0] alu_lvl_q, alu_lvl_d, mem_lvl_q, mem_lvl_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [4:0]    wta_q, wta_d;
    logic [31:0]   wtd_q, wtd_d;
    logic          cnt_q, cnt_d;

    logic          alu_push, mem_push, alu_pop, mem_pop;
    logic          alu_ne, mem_ne;
    logic [EW-1:0] pop_ent;

    // Ready is decoded from the current level only, so a full queue never
    // accepts even when it is popped in the same cycle.
    assign alu_rdy = !rst && (alu_lvl_q != LW'(DEPTH));
    assign mem_rdy = !rst && (mem_lvl_q != LW'(DEPTH));

    // Arbitration, starvation tracking, pointer/level and output next-state
    always_comb begin
        alu_push = alu_vld && alu_rdy;
        mem_push = mem_vld && mem_rdy;
        alu_ne   = (alu_lvl_q != '0);
        mem_ne   = (mem_lvl_q != '0);

        // Memory wins unless the ALU has already lost STARVE times in a row
        mem_pop  = mem_ne && (starve_q < SW'(STARVE));
        alu_pop  = alu_ne && !mem_pop;

        // Counts only losses of a waiting ALU; any other outcome clears it.
        // mem_pop implies starve_q < STARVE, so the increment cannot overflow.
        starve_d = '0;
        if (alu_ne && mem_pop) begin
            starve_d = starve_q + SW'(1);
        end

        alu_wr_d  = alu_wr_q + AW'(alu_push);
        alu_rd_d  = alu_rd_q + AW'(alu_pop);
        mem_wr_d  = mem_wr_q + AW'(mem_push);
        mem_rd_d  = mem_rd_q + AW'(mem_pop);
        alu_lvl_d = alu_lvl_q + LW'(alu_push) - LW'(alu_pop);
        mem_lvl_d = mem_lvl_q + LW'(mem_push) - LW'(mem_pop);

        pop_ent = mem_pop ? mem_mem_q[mem_rd_q] : alu_mem_q[alu_rd_q];

        // Address/data hold between writes; r0 writes are consumed but not enabled
        wta_d = wta_q;
        wtd_d = wtd_q;
        cnt_d = 1'b0;
        if (mem_pop || alu_pop) begin
            wta_d = pop_ent[36:32];
            wtd_d = pop_ent[31:0];
            cnt_d = (pop_ent[36:32] != 5'd0);
        end
    end

    // Control and output registers; reset discards queued entries and drops cnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_wr_q  <= '0;
            alu_rd_q  <= '0;
            mem_wr_q  <= '0;
            mem_rd_q  <= '0;
            alu_lvl_q <= '0;
            mem_lvl_q <= '0;
            starve_q  <= '0;
            wta_q     <= '0;
            wtd_q     <= '0;
            cnt_q     <= 1'b0;
        end else begin
            alu_wr_q  <= alu_wr_d;
            alu_rd_q  <= alu_rd_d;
            mem_wr_q  <= mem_wr_d;
            mem_rd_q  <= mem_rd_d;
            alu_lvl_q <= alu_lvl_d;
            mem_lvl_q <= mem_lvl_d;
            starve_q  <= starve_d;
            wta_q     <= wta_d;
            wtd_q     <= wtd_d;
            cnt_q     <= cnt_d;
        end
    end

    // FIFO storage writes at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_mem_q[alu_wr_q] <= {alu_wta, alu_wtd};
        end
        if (mem_push) begin
            mem_mem_q[mem_wr_q] <= {mem_wta, mem_wtd};
        end
    end

    assign wta     = wta_q;
    assign wtd     = wtd_q;
    assign cnt     = cnt_q;
    assign alu_lvl = alu_lvl_q;
    assign mem_lvl = mem_lvl_q;
    assign busy    = (alu_lvl_q != '0) || (mem_lvl_q != '0) || cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the arbiter.
module tb_wb_arbiter;

    localparam int DEPTH  = 4;
    localparam int LW     = 3;
    localparam int STARVE = 3;

    typedef logic [36:0] ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_vld, mem_vld;
    logic          alu_rdy, mem_rdy;
    logic [4:0]    alu_wta, mem_wta;
    logic [31:0]   alu_wtd, mem_wtd;
    logic [31:0]   wtd;
    logic [4:0]    wta;
    logic          cnt;
    logic [LW-1:0] alu_lvl, mem_lvl;
    logic          busy;

    wb_arbiter #(.DEPTH(DEPTH), .LW(LW), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_wta(alu_wta), .alu_wtd(alu_wtd),
        .mem_vld(mem_vld), .mem_rdy(mem_rdy), .mem_wta(mem_wta), .mem_wtd(mem_wtd),
        .wtd(wtd), .wta(wta), .cnt(cnt),
        .alu_lvl(alu_lvl), .mem_lvl(mem_lvl), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    ent_t        aq[$];
    ent_t        mq[$];
    int          starve_m = 0;
    logic [4:0]  wta_m = '0;
    logic [31:0] wtd_m = '0;
    logic        cnt_m = 1'b0;

    // Source-side pending items (held until accepted)
    logic a_has = 1'b0, m_has = 1'b0;
    ent_t a_item = '0, m_item = '0;

    int   alu_wins = 0;
    logic saw_alu_full = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic gen(input int pa, input int pm, input int amin, input int amax,
                       input int mmin, input int mmax);
        if (!a_has && ($urandom_range(0, 99) < pa)) begin
            a_has  = 1'b1;
            a_item = {5'($urandom_range(amin, amax)), 32'($urandom)};
        end
        if (!m_has && ($urandom_range(0, 99) < pm)) begin
            m_has  = 1'b1;
            m_item = {5'($urandom_range(mmin, mmax)), 32'($urandom)};
        end
    endtask

    // One clock cycle: present pending items, check ready, advance model, check outputs.
    // Entered and left 1 time unit after a rising edge.
    task automatic step();
        logic ar, mr;
        logic popped;
        ent_t e;
        alu_vld = a_has;
        alu_wta = a_item[36:32];
        alu_wtd = a_item[31:0];
        mem_vld = m_has;
        mem_wta = m_item[36:32];
        mem_wtd = m_item[31:0];
        ar = (aq.size() < DEPTH);
        mr = (mq.size() < DEPTH);
        #1;
        check("alu_rdy", 32'(alu_rdy), 32'(ar));
        check("mem_rdy", 32'(mem_rdy), 32'(mr));
        if (!ar) saw_alu_full = 1'b1;

        popped = 1'b0;
        e = '0;
        if (mq.size() > 0 && starve_m < STARVE) begin
            starve_m = (aq.size() > 0) ? ((starve_m + 1 > STARVE) ? STARVE : starve_m + 1) : 0;
            e = mq.pop_front();
            popped = 1'b1;
        end else if (aq.size() > 0) begin
            e = aq.pop_front();
            popped = 1'b1;
            starve_m = 0;
        end else begin
            starve_m = 0;
        end
        if (popped) begin
            wta_m = e[36:32];
            wtd_m = e[31:0];
            cnt_m = (e[36:32] != 5'd0);
        end else begin
            cnt_m = 1'b0;
        end
        if (a_has && ar) begin
            aq.push_back(a_item);
            a_has = 1'b0;
        end
        if (m_has && mr) begin
            mq.push_back(m_item);
            m_has = 1'b0;
        end

        @(posedge clk);
        #1;
        check("cnt", 32'(cnt), 32'(cnt_m));
        check("wta", 32'(wta), 32'(wta_m));
        check("wtd", wtd, wtd_m);
        check("alu_lvl", 32'(alu_lvl), 32'(aq.size()));
        check("mem_lvl", 32'(mem_lvl), 32'(mq.size()));
        check("busy", 32'(busy), 32'((aq.size() != 0) || (mq.size() != 0) || cnt_m));
    endtask

    task automatic model_reset();
        aq.delete();
        mq.delete();
        starve_m = 0;
        wta_m = '0;
        wtd_m = '0;
        cnt_m = 1'b0;
        a_has = 1'b0;
        m_has = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_cnt"}, 32'(cnt), 32'd0);
        check({pfx, "_wta"}, 32'(wta), 32'd0);
        check({pfx, "_wtd"}, wtd, 32'd0);
        check({pfx, "_alu_lvl"}, 32'(alu_lvl), 32'd0);
        check({pfx, "_mem_lvl"}, 32'(mem_lvl), 32'd0);
        check({pfx, "_alu_rdy"}, 32'(alu_rdy), 32'd0);
        check({pfx, "_mem_rdy"}, 32'(mem_rdy), 32'd0);
        check({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        alu_vld = 1'b0; alu_wta = '0; alu_wtd = '0;
        mem_vld = 1'b0; mem_wta = '0; mem_wtd = '0;
        #2;
        check_all_zero("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rel_alu_rdy", 32'(alu_rdy), 32'd1);
        check("rel_mem_rdy", 32'(mem_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Single ALU write: visible only in the cycle after the second edge
        a_has = 1'b1; a_item = {5'd5, 32'h0000_00AA};
        step();
        check("single_pre_cnt", 32'(cnt), 32'd0);
        step();
        check("single_cnt", 32'(cnt), 32'd1);
        check("single_wta", 32'(wta), 32'd5);
        check("single_wtd", wtd, 32'h0000_00AA);
        step();
        check("single_cnt_drop", 32'(cnt), 32'd0);
        check("single_busy_drop", 32'(busy), 32'd0);

        // r0 write is consumed without enabling the register file
        m_has = 1'b1; m_item = {5'd0, 32'hDEAD_BEEF};
        step();
        step();
        check("r0_cnt", 32'(cnt), 32'd0);
        check("r0_wta", 32'(wta), 32'd0);
        check("r0_wtd", wtd, 32'hDEAD_BEEF);
        check("r0_mem_lvl", 32'(mem_lvl), 32'd0);

        // Back-to-back memory writes emerge in order on consecutive cycles
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) begin
                m_has = 1'b1;
                m_item = {5'(i), 32'(i * 32'h111)};
            end
            step();
            if (i >= 2) begin
                check("bp_order_wta", 32'(wta), 32'(i - 1));
                check("bp_order_cnt", 32'(cnt), 32'd1);
            end
        end

        // Saturated contention: ALU wins exactly one of every STARVE+1 grants
        for (int i = 0; i < 40; i++) begin
            gen(100, 100, 16, 31, 1, 15);
            step();
            if (i >= 24 && cnt && wta >= 5'd16) alu_wins++;
        end
        check("starve_alu_wins", 32'(alu_wins), 32'd4);
        check("alu_full_seen", 32'(saw_alu_full), 32'd1);

        // Asynchronous reset in the middle of traffic
        gen(100, 100, 16, 31, 1, 15);
        alu_vld = a_has; mem_vld = m_has;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        @(posedge clk);
        #1;
        check_all_zero("arst_edge");
        model_reset();
        alu_vld = 1'b0;
        mem_vld = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_rel_alu_rdy", 32'(alu_rdy), 32'd1);
        check("arst_rel_mem_rdy", 32'(mem_rdy), 32'd1);
        step();
        check("arst_no_stale", 32'(cnt), 32'd0);

        // Randomized traffic with varying load, including r0 destinations
        for (int blk = 0; blk < 8; blk++) begin
            int pa, pm;
            pa = $urandom_range(10, 100);
            pm = $urandom_range(10, 100);
            for (int i = 0; i < 100; i++) begin
                gen(pa, pm, 0, 31, 0, 31);
                step();
            end
        end

        // Drain
        for (int i = 0; i < 12; i++) step();
        check("drain_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
